probe_drop_collector: RTL



---
 rtl/probe_drop_pkg.sv | 26 ++
 rtl/probe_drop_fifo.sv | 49 ++++
 rtl/probe_drop_collector.sv | 132 +++++++++++++
 3 files changed

// File: rtl/probe_drop_pkg.sv
// Shared types and helpers for the RX drop probe collector.
package probe_drop_pkg;

  localparam int MAX_REGIONS = 8;
  localparam int PCNT_W      = 4;

  // Per-word buffered record; regions above REGIONS stay zero.
  typedef struct packed {
    logic [MAX_REGIONS-1:0] eof;
    logic [MAX_REGIONS-1:0] drop;
  } word_t;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  function automatic int region_w(input int regions);
    return (regions > 1) ? $clog2(regions) : 1;
  endfunction

  function automatic logic [PCNT_W-1:0] popcount(input logic [MAX_REGIONS-1:0] v);
    logic [PCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_REGIONS; i++) n = n + PCNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/probe_drop_fifo.sv
// Register-based FIFO; a write while full is accepted when a pop happens in the same cycle.
module probe_drop_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_wr, do_rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = wr_i & (~full_o | do_rd);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AW'(1);
      if (do_rd) rptr_q <= rptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/probe_drop_collector.sv
// Consumes RX drop probe words: saturating pass/drop/lost counters plus an
// in-order per-frame event stream with valid/ready handshake.
module probe_drop_collector
  import probe_drop_pkg::*;
#(
  parameter  int REGIONS    = 4,
  parameter  int FIFO_DEPTH = 16,
  parameter  int CNT_WIDTH  = 32,
  localparam int IW         = region_w(REGIONS)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 PROBE_VLD,
  input  logic [2*REGIONS-1:0] PROBE_DATA,
  input  logic                 CNT_CLR,
  output logic [IW-1:0]        EV_REGION,
  output logic                 EV_DROP,
  output logic                 EV_SRC_RDY,
  input  logic                 EV_DST_RDY,
  output logic [CNT_WIDTH-1:0] CNT_PASS,
  output logic [CNT_WIDTH-1:0] CNT_DROP,
  output logic [CNT_WIDTH-1:0] CNT_LOST,
  output logic                 OVF
);

  logic [MAX_REGIONS-1:0] eof_q, drp_q;
  logic [CNT_WIDTH-1:0]   pass_q, pass_d, drop_q, drop_d, lost_q, lost_d;
  logic                   ovf_q, ovf_d;
  logic                   cand, lost, pop, full, empty, fifo_wr;
  word_t                  wr_word, rd_word;
  state_e                 state_q;
  logic [MAX_REGIONS-1:0] mask_q, dmask_q, low;
  logic                   last, accept;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] base,
                                                   input logic [PCNT_W-1:0]    inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, base} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // Input stage: valid folded into the masks, drop qualified by eof.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      eof_q <= '0;
      drp_q <= '0;
    end else begin
      eof_q <= PROBE_VLD ? MAX_REGIONS'(PROBE_DATA[2*REGIONS-1:REGIONS]) : '0;
      drp_q <= PROBE_VLD ? MAX_REGIONS'(PROBE_DATA[REGIONS-1:0] &
                                        PROBE_DATA[2*REGIONS-1:REGIONS]) : '0;
    end
  end

  assign cand         = |eof_q;
  assign wr_word.eof  = eof_q;
  assign wr_word.drop = drp_q;
  assign fifo_wr      = cand & (~full | pop);
  assign lost         = cand & full & ~pop;

  // Clear loads this cycle's increment so nothing seen at the clear edge is lost.
  always_comb begin
    pass_d = sat_add(CNT_CLR ? '0 : pass_q, popcount(eof_q & ~drp_q));
    drop_d = sat_add(CNT_CLR ? '0 : drop_q, popcount(drp_q));
    lost_d = sat_add(CNT_CLR ? '0 : lost_q, PCNT_W'(lost));
    ovf_d  = lost | (ovf_q & ~CNT_CLR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pass_q <= '0;
      drop_q <= '0;
      lost_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pass_q <= pass_d;
      drop_q <= drop_d;
      lost_q <= lost_d;
      ovf_q  <= ovf_d;
    end
  end

  assign CNT_PASS = pass_q;
  assign CNT_DROP = drop_q;
  assign CNT_LOST = lost_q;
  assign OVF      = ovf_q;

  probe_drop_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr_i    (fifo_wr),
    .wdata_i (wr_word),
    .rd_i    (pop),
    .rdata_o (rd_word),
    .full_o  (full),
    .empty_o (empty)
  );

  // Serializer: lowest pending region first; reload on the last accept to avoid bubbles.
  assign low    = mask_q & (~mask_q + MAX_REGIONS'(1));
  assign last   = ((mask_q & ~low) == '0);
  assign accept = (state_q == EMIT) & EV_DST_RDY;
  assign pop    = ~empty & ((state_q == IDLE) | (accept & last));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dmask_q <= '0;
    end else if (pop) begin
      state_q <= EMIT;
      mask_q  <= rd_word.eof;
      dmask_q <= rd_word.drop;
    end else if (accept) begin
      mask_q <= mask_q & ~low;
      if (last) state_q <= IDLE;
    end
  end

  always_comb begin
    EV_REGION = '0;
    for (int r = 0; r < REGIONS; r++) begin
      if (low[r]) EV_REGION = IW'(r);
    end
  end

  assign EV_SRC_RDY = (state_q == EMIT);
  assign EV_DROP    = |(dmask_q & low);

endmodule
